// File: rtl/wb_commit_if.sv
// Bundle between the MEM/WB register, the register file and the syscall
// event consumer. The master drives the commit bundle; the slave is the commit unit.
interface wb_commit_if #(
  parameter int LANES  = 2,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 32
);
  logic [LANES-1:0]        wb_valid;
  logic [LANES-1:0]        wb_flush;
  logic [LANES-1:0]        wb_reg_write;
  logic [LANES*5-1:0]      wb_addr;
  logic [LANES*DATA_W-1:0] wb_data;
  logic [LANES-1:0]        wb_is_syscall;
  logic [LANES*DATA_W-1:0] wb_sys_code;
  logic [LANES*DATA_W-1:0] wb_sys_arg;
  logic                    wb_stall;
  logic [LANES-1:0]        rf_we;
  logic [LANES*5-1:0]      rf_waddr;
  logic [LANES*DATA_W-1:0] rf_wdata;
  logic                    evt_valid;
  logic                    evt_ready;
  logic [DATA_W-1:0]       evt_code;
  logic [DATA_W-1:0]       evt_arg;
  logic                    halted;
  logic [CNT_W-1:0]        retire_count;

  modport master (
    output wb_valid, wb_flush, wb_reg_write, wb_addr, wb_data,
           wb_is_syscall, wb_sys_code, wb_sys_arg, evt_ready,
    input  wb_stall, rf_we, rf_waddr, rf_wdata, evt_valid,
           evt_code, evt_arg, halted, retire_count
  );

  modport slave (
    input  wb_valid, wb_flush, wb_reg_write, wb_addr, wb_data,
           wb_is_syscall, wb_sys_code, wb_sys_arg, evt_ready,
    output wb_stall, rf_we, rf_waddr, rf_wdata, evt_valid,
           evt_code, evt_arg, halted, retire_count
  );
endinterface

// File: rtl/wb_commit_unit.sv
// N-lane write-back/commit stage: register-write gating with youngest-writer-wins,
// multi-push syscall event FIFO, retire counter and exit/halt FSM.
module wb_commit_unit #(
  parameter int LANES     = 2,
  parameter int DATA_W    = 32,
  parameter int EVT_DEPTH = 4,
  parameter int CNT_W     = 32,
  parameter int EXIT_CODE = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  wb_commit_if.slave   bus
);
  localparam int AW    = $clog2(EVT_DEPTH);
  localparam int OCC_W = AW + 1;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_HALTED = 2'd2
  } state_t;

  state_t              state_r;
  state_t              state_nxt_s;
  logic [DATA_W-1:0]   code_mem_r [EVT_DEPTH];
  logic [DATA_W-1:0]   arg_mem_r  [EVT_DEPTH];
  logic [AW-1:0]       wr_ptr_r;
  logic [AW-1:0]       rd_ptr_r;
  logic [OCC_W-1:0]    count_r;
  logic [CNT_W-1:0]    retire_count_r;

  logic [LANES-1:0]    live_s;
  logic [LANES-1:0]    is_exit_s;
  logic [LANES-1:0]    commit_s;
  logic [LANES-1:0]    push_en_s;
  logic [LANES-1:0]    rf_we_s;
  logic [AW-1:0]       push_idx_s [LANES];
  logic [OCC_W-1:0]    k_s;
  logic [OCC_W-1:0]    free_s;
  logic [OCC_W-1:0]    n_push_s;
  logic [CNT_W-1:0]    retire_inc_s;
  logic                stall_s;
  logic                exit_commit_s;
  logic                pop_s;
  logic                run_s;
  logic                halted_s;

  // Live lanes, exit detection and the count of live syscalls needing FIFO room
  always_comb begin
    k_s = {OCC_W{1'b0}};
    for (int i = 0; i < LANES; i++) begin
      live_s[i]    = bus.wb_valid[i] & ~bus.wb_flush[i];
      is_exit_s[i] = live_s[i] & bus.wb_is_syscall[i] &
                     (bus.wb_sys_code[i*DATA_W +: DATA_W] == DATA_W'(EXIT_CODE));
      if (live_s[i] & bus.wb_is_syscall[i]) begin
        k_s = k_s + OCC_W'(1'b1);
      end else begin
        k_s = k_s;
      end
    end
    free_s  = OCC_W'(EVT_DEPTH) - count_r;
    stall_s = ~run_s | (k_s > free_s);
  end

  // Commit mask (lanes younger than an exit are dropped) and in-order push slots
  always_comb begin : commit_comb
    logic exit_seen_v;
    exit_seen_v   = 1'b0;
    n_push_s      = {OCC_W{1'b0}};
    retire_inc_s  = {CNT_W{1'b0}};
    exit_commit_s = 1'b0;
    for (int i = 0; i < LANES; i++) begin
      commit_s[i]   = ~stall_s & live_s[i] & ~exit_seen_v;
      exit_seen_v   = exit_seen_v | is_exit_s[i];
      exit_commit_s = exit_commit_s | (commit_s[i] & is_exit_s[i]);
      push_en_s[i]  = commit_s[i] & bus.wb_is_syscall[i];
      push_idx_s[i] = wr_ptr_r + n_push_s[AW-1:0];
      if (push_en_s[i]) begin
        n_push_s = n_push_s + OCC_W'(1'b1);
      end else begin
        n_push_s = n_push_s;
      end
      retire_inc_s = retire_inc_s + CNT_W'(commit_s[i]);
    end
  end

  // Register-file enables: a younger committed writer to the same register shadows older lanes
  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      rf_we_s[i] = commit_s[i] & bus.wb_reg_write[i] & (bus.wb_addr[i*5 +: 5] != 5'd0);
      for (int j = i + 1; j < LANES; j++) begin
        if (commit_s[j] & bus.wb_reg_write[j] &
            (bus.wb_addr[j*5 +: 5] == bus.wb_addr[i*5 +: 5])) begin
          rf_we_s[i] = 1'b0;
        end else begin
          rf_we_s[i] = rf_we_s[i];
        end
      end
    end
  end

  assign pop_s = (count_r != {OCC_W{1'b0}}) & bus.evt_ready;

  // Event storage; occupancy tracking makes a reset of the contents unnecessary
  always_ff @(posedge clk) begin
    for (int i = 0; i < LANES; i++) begin
      if (push_en_s[i]) begin
        code_mem_r[push_idx_s[i]] <= bus.wb_sys_code[i*DATA_W +: DATA_W];
        arg_mem_r[push_idx_s[i]]  <= bus.wb_sys_arg[i*DATA_W +: DATA_W];
      end
    end
  end

  // FIFO pointers, occupancy and retire counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r       <= {AW{1'b0}};
      rd_ptr_r       <= {AW{1'b0}};
      count_r        <= {OCC_W{1'b0}};
      retire_count_r <= {CNT_W{1'b0}};
    end else begin
      wr_ptr_r       <= wr_ptr_r + n_push_s[AW-1:0];
      rd_ptr_r       <= rd_ptr_r + AW'(pop_s);
      count_r        <= count_r + n_push_s - OCC_W'(pop_s);
      retire_count_r <= retire_count_r + retire_inc_s;
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_RUN;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next state: the exit syscall itself enqueues, so DRAIN waits for its pop too
  always_comb begin
    case (state_r)
      ST_RUN:    state_nxt_s = exit_commit_s ? ST_DRAIN : ST_RUN;
      ST_DRAIN:  state_nxt_s = (count_r == {OCC_W{1'b0}}) ? ST_HALTED : ST_DRAIN;
      ST_HALTED: state_nxt_s = ST_HALTED;
      default:   state_nxt_s = ST_RUN;
    endcase
  end

  // FSM outputs
  always_comb begin
    case (state_r)
      ST_RUN:    begin run_s = 1'b1; halted_s = 1'b0; end
      ST_DRAIN:  begin run_s = 1'b0; halted_s = 1'b0; end
      ST_HALTED: begin run_s = 1'b0; halted_s = 1'b1; end
      default:   begin run_s = 1'b0; halted_s = 1'b0; end
    endcase
  end

  assign bus.wb_stall     = stall_s;
  assign bus.rf_we        = rf_we_s;
  assign bus.rf_waddr     = bus.wb_addr;
  assign bus.rf_wdata     = bus.wb_data;
  assign bus.evt_valid    = (count_r != {OCC_W{1'b0}});
  assign bus.evt_code     = code_mem_r[rd_ptr_r];
  assign bus.evt_arg      = arg_mem_r[rd_ptr_r];
  assign bus.halted       = halted_s;
  assign bus.retire_count = retire_count_r;
endmodule
